// File: rtl/mod_counter.sv
// Modulo up/down counter with load, optional saturation, wrap pulse and terminal count.
// Count range is 0..MODULUS-1, and all arithmetic stays within COUNTER_WIDTH bits.
module mod_counter #(
   parameter int COUNTER_WIDTH = 8,
   parameter int MODULUS       = 256,
   parameter bit SATURATE      = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     up,
   input  logic                     load,
   input  logic [COUNTER_WIDTH-1:0] load_val,
   output logic [COUNTER_WIDTH-1:0] dout,
   output logic                     wrap,
   output logic                     sat,
   output logic                     tc
);

   // MODULUS may equal 2**COUNTER_WIDTH, so the top value is formed before narrowing.
   localparam logic [COUNTER_WIDTH-1:0] MAX_VAL = COUNTER_WIDTH'(MODULUS - 1);

   logic [COUNTER_WIDTH-1:0] count_q, count_d;
   logic                     wrap_q, wrap_d;
   logic                     sat_q, sat_d;
   logic                     at_top, at_bot;

   assign at_top = (count_q == MAX_VAL);
   assign at_bot = (count_q == '0);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      count_d = count_q;
      wrap_d  = 1'b0;
      sat_d   = sat_q;

      if (load) begin
         count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
         sat_d   = 1'b0;
      end else if (en) begin
         if (up) begin
            if (!at_top) begin
               count_d = count_q + 1'b1;
               sat_d   = 1'b0;
            end else if (SATURATE) begin
               sat_d = 1'b1;
            end else begin
               count_d = '0;
               wrap_d  = 1'b1;
            end
         end else begin
            if (!at_bot) begin
               count_d = count_q - 1'b1;
               sat_d   = 1'b0;
            end else if (SATURATE) begin
               sat_d = 1'b1;
            end else begin
               count_d = MAX_VAL;
               wrap_d  = 1'b1;
            end
         end
      end

      if (!SATURATE) sat_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         sat_q   <= sat_d;
      end
   end

   assign dout = count_q;
   assign wrap = wrap_q;
   assign sat  = sat_q;
   assign tc   = up ? at_top : at_bot;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench: three counter configurations share one stimulus stream and are
// compared every cycle against a plain arithmetic model, plus literal scenario checks.
module tb_mod_counter;

   localparam int NDUT = 3;
   localparam int MODS [NDUT] = '{10, 10, 16};
   localparam bit SATS [NDUT] = '{1'b0, 1'b1, 1'b0};

   logic       clk = 1'b0;
   logic       rst, en, up, load;
   logic [3:0] load_val;
   logic [3:0] dout [NDUT];
   logic       wrap [NDUT];
   logic       sat  [NDUT];
   logic       tc   [NDUT];

   int total = 0;
   int bad   = 0;

   int m_cnt  [NDUT];
   bit m_wrap [NDUT];
   bit m_sat  [NDUT];
   bit m_valid = 1'b0;

   always #5 clk = ~clk;

   mod_counter #(.COUNTER_WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap10 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .dout(dout[0]), .wrap(wrap[0]), .sat(sat[0]), .tc(tc[0]));

   mod_counter #(.COUNTER_WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat10 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .dout(dout[1]), .wrap(wrap[1]), .sat(sat[1]), .tc(tc[1]));

   mod_counter #(.COUNTER_WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_wrap16 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .dout(dout[2]), .wrap(wrap[2]), .sat(sat[2]), .tc(tc[2]));

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference behaviour: one edge of the counter written as plain integer rules.
   always @(posedge clk) begin
      for (int i = 0; i < NDUT; i++) begin
         int top;
         top = MODS[i] - 1;
         if (rst) begin
            m_cnt[i] <= 0; m_wrap[i] <= 1'b0; m_sat[i] <= 1'b0;
         end else if (load) begin
            m_cnt[i] <= (int'(load_val) > top) ? top : int'(load_val);
            m_wrap[i] <= 1'b0; m_sat[i] <= 1'b0;
         end else if (en) begin
            int next;
            next = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
            if (next >= 0 && next <= top) begin
               m_cnt[i] <= next; m_wrap[i] <= 1'b0; m_sat[i] <= 1'b0;
            end else if (SATS[i]) begin
               m_wrap[i] <= 1'b0; m_sat[i] <= 1'b1;
            end else begin
               m_cnt[i] <= (next + MODS[i]) % MODS[i];
               m_wrap[i] <= 1'b1; m_sat[i] <= 1'b0;
            end
         end else begin
            m_wrap[i] <= 1'b0;
         end
      end
      if (rst) m_valid <= 1'b1;
   end

   // Compare process: outputs are stable mid-cycle, inputs change just after posedge.
   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < NDUT; i++) begin
            int top;
            top = MODS[i] - 1;
            check($sformatf("model_dout[%0d]", i), int'(dout[i]), m_cnt[i]);
            check($sformatf("model_wrap[%0d]", i), int'(wrap[i]), int'(m_wrap[i]));
            check($sformatf("model_sat[%0d]", i), int'(sat[i]), int'(m_sat[i]));
            check($sformatf("model_tc[%0d]", i), int'(tc[i]),
                  int'(up ? (m_cnt[i] == top) : (m_cnt[i] == 0)));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit r, input bit l, input bit e, input bit u, input int lv);
      rst = r; load = l; en = e; up = u; load_val = 4'(lv);
   endtask

   initial begin
      int exp31 [12];
      int exp32 [5];
      exp31 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      exp32 = '{2, 1, 0, 9, 8};

      drive(1, 0, 0, 1, 0);
      step();
      check("reset_dout", int'(dout[0]), 0);
      check("reset_wrap", int'(wrap[0]), 0);
      check("reset_sat",  int'(sat[1]), 0);

      // Up-count through a wrap.
      drive(0, 0, 1, 1, 0);
      for (int k = 0; k < 12; k++) begin
         check("tc_before_edge", int'(tc[0]), int'(k == 9));
         step();
         check("up_dout", int'(dout[0]), exp31[k]);
         check("up_wrap", int'(wrap[0]), int'(exp31[k] == 0 && k == 9));
      end

      // Load then count down through a wrap.
      drive(0, 1, 0, 0, 3);
      step();
      check("load3_dout", int'(dout[0]), 3);
      drive(0, 0, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("down_dout", int'(dout[0]), exp32[k]);
         check("down_wrap", int'(wrap[0]), int'(k == 3));
      end

      // Saturating instance holds at the top, then releases on direction change.
      drive(0, 1, 0, 1, 8);
      step();
      check("sat_load8", int'(dout[1]), 8);
      drive(0, 0, 1, 1, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         check("sat_dout", int'(dout[1]), 9);
         check("sat_flag", int'(sat[1]), int'(k >= 1));
         check("sat_nowrap", int'(wrap[1]), 0);
      end
      drive(0, 0, 1, 0, 0);
      step();
      check("sat_release_dout", int'(dout[1]), 8);
      check("sat_release_flag", int'(sat[1]), 0);

      // Load clamps and wins over enable.
      drive(0, 1, 1, 1, 15);
      step();
      check("clamp_dout", int'(dout[0]), 9);
      check("clamp_wrap", int'(wrap[0]), 0);
      check("clamp16_dout", int'(dout[2]), 15);

      // Reset overrides load at the wrap point, then counting restarts from 0.
      drive(1, 1, 1, 1, 5);
      step();
      check("rst_over_load_dout", int'(dout[0]), 0);
      check("rst_over_load_wrap", int'(wrap[0]), 0);
      drive(0, 0, 1, 1, 0);
      step();
      check("post_rst_dout", int'(dout[0]), 1);

      // Full binary range: 15 -> 0 with wrap, then idle clears wrap.
      drive(0, 1, 0, 1, 15);
      step();
      check("m16_load", int'(dout[2]), 15);
      drive(0, 0, 1, 1, 0);
      step();
      check("m16_wrap_dout", int'(dout[2]), 0);
      check("m16_wrap_pulse", int'(wrap[2]), 1);
      drive(0, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("m16_idle_dout", int'(dout[2]), 0);
         check("m16_idle_wrap", int'(wrap[2]), 0);
      end

      // Randomised traffic checked by the model every cycle.
      for (int k = 0; k < 3000; k++) begin
         drive($urandom_range(49) == 0, $urandom_range(7) == 0,
               $urandom_range(3) != 0, $urandom_range(1) == 1, int'($urandom_range(15)));
         step();
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 8: width of count and load value.
REQ-002 SHALL have parameter MODULUS, default 256: count range 0..MODULUS-1; legal range 2..2**COUNTER_WIDTH.
REQ-003 SHALL have parameter SATURATE, default 0: 0 means wrap at range ends, 1 means hold at range ends.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port up, input, 1 bit: direction; 1 means increment, 0 means decrement.
REQ-008 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, COUNTER_WIDTH bits: value to load.
REQ-010 SHALL have port dout, output reg, COUNTER_WIDTH bits: current count.
REQ-011 SHALL have port wrap, output reg, 1 bit: one-cycle pulse marking a wrap event (SATURATE=0 only).
REQ-012 SHALL have port sat, output reg, 1 bit: level flag, high while held at a range end (SATURATE=1 only).
REQ-013 SHALL have port tc, output, 1 bit, combinational: terminal count; high when dout==MODULUS-1 and up=1, or when dout==0 and up=0.

Function
REQ-014 SHALL apply priority per edge: rst, then load, then en, then hold.
REQ-015 SHALL, on load=1, set dout to min(load_val, MODULUS-1), clear wrap and clear sat, regardless of en.
REQ-016 SHALL, with en=1, up=1 and dout<MODULUS-1, set dout to dout+1.
REQ-017 SHALL, with en=1, up=0 and dout>0, set dout to dout-1.
REQ-018 SHALL, with en=1, up=1, dout==MODULUS-1 and SATURATE=0, set dout to 0 and set wrap=1 on that same edge.
REQ-019 SHALL, with en=1, up=0, dout==0 and SATURATE=0, set dout to MODULUS-1 and set wrap=1 on that same edge.
REQ-020 SHALL, in SATURATE=1, hold dout at MODULUS-1 (counting up) or at 0 (counting down) and set sat=1 on a count attempt past the end.
REQ-021 SHALL clear sat on any edge where dout changes value, and on load.
REQ-022 SHALL keep wrap high for exactly one cycle per wrap event, and clear it on every edge without a wrap event, including en=0.
REQ-023 SHALL keep dout, wrap and sat unchanged when en=0 and load=0, except for the wrap clear required by REQ-022.
REQ-024 SHALL hold wrap at 0 when SATURATE=1 and hold sat at 0 when SATURATE=0.
REQ-025 SHALL perform all arithmetic in COUNTER_WIDTH bits with no overflow reachable; MODULUS=2**COUNTER_WIDTH is legal and SHALL behave as natural binary wrap.
REQ-026 SHALL allow direction change on any cycle with no gap; the new direction applies on the same edge.
REQ-027 SHALL give counting latency of one clock: dout reflects en, up and load sampled at the preceding edge.

Reset
REQ-028 SHALL, on rst=1 at a rising edge, set dout=0, wrap=0 and sat=0, overriding load and en.
REQ-029 SHALL restart counting from 0 on the first edge after rst deasserts if en=1, including when rst occurs mid-count or mid-wrap.
REQ-030 SHALL leave dout undefined before the first reset; no initial values are required.

Verification (W=4, MODULUS=10 unless noted)
REQ-031 SHALL test: rst, then en=1, up=1 for 12 cycles -> dout 1..9, 0, 1, 2; wrap high only in the cycle dout=0; tc high at dout=9.
REQ-032 SHALL test: load_val=3 with load=1, then en=1, up=0 for 5 cycles -> dout 3, 2, 1, 0, 9, 8; wrap high with dout=9.
REQ-033 SHALL test with SATURATE=1: load 8, en=1, up=1 for 4 cycles -> dout 9, 9, 9, 9; sat=1 from the second 9; then up=0 -> dout 8 and sat=0.
REQ-034 SHALL test: load_val=15 with load=1 and en=1 on the same edge -> dout=9 (clamped, no increment); wrap=0.
REQ-035 SHALL test: counting at dout=9, rst=1 and load=1 on the same edge -> dout=0, wrap=0; next edge with en=1 -> dout=1.
REQ-036 SHALL test with MODULUS=16: from dout=15, en=1, up=1 -> dout=0 and wrap=1; en=0 for 3 cycles -> dout=0, wrap=0.
